ec_scalar_seq: RTL and testbench

- Parametrised scalar-multiplication sequencer; successor to the fixed-256-bit ECpoint_scalar control path.
- Scans scalar k and issues point-operation commands (CLR/LOAD/DBL/ADD) to an external point-arithmetic engine over a valid/done handshake.
- Two modes:
  - variable-time left-to-right double-and-add (skips leading zeros);
  - constant-time Montgomery ladder (scans all bits).
- Result is left in engine register R0.

---
 rtl/ec_scalar_seq.sv | 230 +++++++++++++++++++++++
 tb/tb_ec_scalar_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ec_scalar_seq.sv
// ---------------------------------------------------------------------------
// ec_scalar_seq -- scalar-multiplication sequencer.
//
// Scans scalar k and drives an external point-arithmetic engine, one command
// at a time, so that the engine's R0 ends up holding k*P.
//   MODE 0: variable-time left-to-right double-and-add (leading zeros skipped)
//   MODE 1: constant-time Montgomery ladder (every bit costs DBL + ADD)
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   start, k      job request (sampled in IDLE only) and scalar
//   busy          job in progress (LOCATE .. last command)
//   op_valid      command valid; op_code/op_dst stable while high
//   op_code       0 CLR, 1 LOAD, 2 DBL, 3 ADD
//   op_dst        destination register (0 = R0, 1 = R1)
//   op_done       engine completion pulse (ignored unless op_valid)
//   done          one-cycle completion pulse, result in R0
//   result_inf    k was zero; result is the point at infinity
//   op_cnt        commands completed for this job, saturating
//
// Handshake: a command transfers on every cycle with op_valid & op_done.
// The sequencer holds op_valid/op_code/op_dst constant until that cycle and
// may present the next command on the very next cycle.
// ---------------------------------------------------------------------------
module ec_scalar_seq #(
    parameter int BW_K   = 256,
    parameter int MODE   = 0,
    parameter int BW_CNT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BW_K-1:0]   k,
    output logic              busy,
    output logic              op_valid,
    output logic [1:0]        op_code,
    output logic              op_dst,
    input  logic              op_done,
    output logic              done,
    output logic              result_inf,
    output logic [BW_CNT-1:0] op_cnt
);
    localparam int IW = $clog2(BW_K);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOCATE = 3'd1;
    localparam logic [2:0] S_INIT0  = 3'd2;
    localparam logic [2:0] S_INIT1  = 3'd3;
    localparam logic [2:0] S_BIT_A  = 3'd4;
    localparam logic [2:0] S_BIT_B  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    localparam logic [1:0] OP_CLR  = 2'd0;
    localparam logic [1:0] OP_LOAD = 2'd1;
    localparam logic [1:0] OP_DBL  = 2'd2;
    localparam logic [1:0] OP_ADD  = 2'd3;

    logic [2:0]        state_q, state_d;
    logic [BW_K-1:0]   k_q, k_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              valid_q, valid_d;
    logic [1:0]        code_q, code_d;
    logic              dst_q, dst_d;
    logic              inf_q, inf_d;
    logic [BW_CNT-1:0] cnt_q, cnt_d;

    logic [IW-1:0]     msb_pos;
    logic [IW-1:0]     idx_m1;
    logic              k_zero;
    logic              bit_cur;
    logic              bit_nxt;
    logic              fire;

    // Leading-one detect: the highest set bit wins.
    always_comb begin
        msb_pos = '0;
        for (int i = 0; i < BW_K; i++) begin
            if (k_q[i]) msb_pos = IW'(i);
        end
    end

    assign k_zero  = ~|k_q;
    assign idx_m1  = idx_q - 1'b1;
    assign bit_cur = k_q[idx_q];
    assign bit_nxt = k_q[idx_m1];
    assign fire    = valid_q & op_done;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        code_d  = code_q;
        dst_d   = dst_q;
        inf_d   = inf_q;
        cnt_d   = cnt_q;

        if (fire && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    k_d     = k;
                    cnt_d   = '0;
                    inf_d   = 1'b0;
                    state_d = S_LOCATE;
                end
            end

            S_LOCATE: begin
                if ((MODE == 0) && k_zero) begin
                    // Nothing to compute: R0 is never touched.
                    inf_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d   = (MODE == 0) ? msb_pos : IW'(BW_K - 1);
                    valid_d = 1'b1;
                    code_d  = (MODE == 0) ? OP_LOAD : OP_CLR;
                    dst_d   = 1'b0;
                    state_d = S_INIT0;
                end
            end

            S_INIT0: begin
                if (fire) begin
                    code_d  = OP_LOAD;
                    dst_d   = 1'b1;
                    state_d = S_INIT1;
                end
            end

            S_INIT1: begin
                if (fire) begin
                    if (MODE == 0) begin
                        // The leading one is absorbed by LOAD R0; scan starts at m-1.
                        if (idx_q == '0) begin
                            valid_d = 1'b0;
                            inf_d   = k_zero;
                            state_d = S_DONE;
                        end else begin
                            idx_d   = idx_m1;
                            code_d  = OP_DBL;
                            dst_d   = 1'b0;
                            state_d = S_BIT_A;
                        end
                    end else begin
                        code_d  = OP_ADD;
                        dst_d   = ~bit_cur;
                        state_d = S_BIT_A;
                    end
                end
            end

            S_BIT_A: begin
                if (fire) begin
                    if (MODE == 0) begin
                        if (bit_cur) begin
                            code_d  = OP_ADD;
                            dst_d   = 1'b0;
                            state_d = S_BIT_B;
                        end else if (idx_q == '0) begin
                            valid_d = 1'b0;
                            inf_d   = k_zero;
                            state_d = S_DONE;
                        end else begin
                            // Zero bit: skip BIT_B, next DBL straight away.
                            idx_d   = idx_m1;
                            code_d  = OP_DBL;
                            dst_d   = 1'b0;
                        end
                    end else begin
                        code_d  = OP_DBL;
                        dst_d   = bit_cur;
                        state_d = S_BIT_B;
                    end
                end
            end

            S_BIT_B: begin
                if (fire) begin
                    if (idx_q == '0) begin
                        valid_d = 1'b0;
                        inf_d   = k_zero;
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_m1;
                        code_d  = (MODE == 0) ? OP_DBL : OP_ADD;
                        dst_d   = (MODE == 0) ? 1'b0 : ~bit_nxt;
                        state_d = S_BIT_A;
                    end
                end
            end

            S_DONE: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            code_q  <= OP_CLR;
            dst_q   <= 1'b0;
            inf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            code_q  <= code_d;
            dst_q   <= dst_d;
            inf_q   <= inf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done       = (state_q == S_DONE);
    assign op_valid   = valid_q;
    assign op_code    = code_q;
    assign op_dst     = dst_q;
    assign result_inf = inf_q;
    assign op_cnt     = cnt_q;

endmodule

// File: tb/tb_ec_scalar_seq.sv
// ---------------------------------------------------------------------------
// Bench for ec_scalar_seq: one double-and-add and one ladder instance
// (BW_K = 8), selected through a small mux. The engine is modelled with
// points as integer multiples of P (CLR -> 0, LOAD -> 1, DBL -> 2x,
// ADD -> R0+R1), so R0 must equal k at the end of every job.
// ---------------------------------------------------------------------------
module tb_ec_scalar_seq;
    localparam int BW_K   = 8;
    localparam int BW_CNT = 16;

    // ---- clock / reset ----------------------------------------------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---- DUT wiring ---------------------------------------------------------
    logic              sel;       // 0 selects double-and-add, 1 the ladder
    logic              start;
    logic [BW_K-1:0]   k_in;
    logic              op_done;

    logic              busy0, valid0, dst0, done0, inf0;
    logic [1:0]        code0;
    logic [BW_CNT-1:0] cnt0;
    logic              busy1, valid1, dst1, done1, inf1;
    logic [1:0]        code1;
    logic [BW_CNT-1:0] cnt1;

    logic              busy, op_valid, op_dst, done, result_inf;
    logic [1:0]        op_code;
    logic [BW_CNT-1:0] op_cnt;

    ec_scalar_seq #(.BW_K(BW_K), .MODE(0), .BW_CNT(BW_CNT)) u_dadd (
        .clk(clk), .rst(rst), .start(start & ~sel), .k(k_in),
        .busy(busy0), .op_valid(valid0), .op_code(code0), .op_dst(dst0),
        .op_done(op_done & ~sel), .done(done0), .result_inf(inf0), .op_cnt(cnt0)
    );

    ec_scalar_seq #(.BW_K(BW_K), .MODE(1), .BW_CNT(BW_CNT)) u_ladder (
        .clk(clk), .rst(rst), .start(start & sel), .k(k_in),
        .busy(busy1), .op_valid(valid1), .op_code(code1), .op_dst(dst1),
        .op_done(op_done & sel), .done(done1), .result_inf(inf1), .op_cnt(cnt1)
    );

    assign busy       = sel ? busy1  : busy0;
    assign op_valid   = sel ? valid1 : valid0;
    assign op_code    = sel ? code1  : code0;
    assign op_dst     = sel ? dst1   : dst0;
    assign done       = sel ? done1  : done0;
    assign result_inf = sel ? inf1   : inf0;
    assign op_cnt     = sel ? cnt1   : cnt0;

    localparam logic [1:0] CLR = 2'd0, LOAD = 2'd1, DBL = 2'd2, ADD = 2'd3;

    // ---- scoreboard ---------------------------------------------------------
    logic [2:0] exp_q[$];         // {op_code, op_dst} in issue order
    int n_checks = 0;
    int n_errors = 0;
    int last_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected command stream straight from the algorithm descriptions.
    task automatic build_expected(input logic [BW_K-1:0] kv, input bit mode);
        int m;
        exp_q.delete();
        if (mode == 1'b0) begin
            if (kv != '0) begin
                m = 0;
                for (int i = 0; i < BW_K; i++) if (kv[i]) m = i;
                exp_q.push_back({LOAD, 1'b0});
                exp_q.push_back({LOAD, 1'b1});
                for (int i = m - 1; i >= 0; i--) begin
                    exp_q.push_back({DBL, 1'b0});
                    if (kv[i]) exp_q.push_back({ADD, 1'b0});
                end
            end
        end else begin
            exp_q.push_back({CLR, 1'b0});
            exp_q.push_back({LOAD, 1'b1});
            for (int i = BW_K - 1; i >= 0; i--) begin
                if (kv[i]) begin
                    exp_q.push_back({ADD, 1'b0});
                    exp_q.push_back({DBL, 1'b1});
                end else begin
                    exp_q.push_back({ADD, 1'b1});
                    exp_q.push_back({DBL, 1'b0});
                end
            end
        end
    endtask

    // ---- driver + engine model ---------------------------------------------
    // maxdly: engine answers 0..maxdly cycles after a command appears.
    // poke:   pulse start mid-job (must be ignored).
    // abort_at: command index at which reset is hit asynchronously (-1 none).
    task automatic run_job(input logic [BW_K-1:0] kv, input bit mode, input int maxdly,
                           input bit poke, input int abort_at);
        logic [2:0]  cur;
        bit          have, fin;
        int          dly, ncmd, exp_len, done_cyc;
        int unsigned r[2];

        build_expected(kv, mode);
        exp_len = exp_q.size();
        sel = mode;
        @(negedge clk);
        k_in  = kv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k_in  = BW_K'($urandom);   // must not matter after acceptance
        check_val("busy_after_start", busy, 1);
        check_val("no_valid_in_locate", op_valid, 0);

        have = 0; fin = 0; ncmd = 0; dly = 0; cur = '0; done_cyc = -1;
        r[0] = 0; r[1] = 0;
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            @(negedge clk);
            op_done = 1'b0;
            start   = 1'b0;
            if (done) begin
                fin = 1;
                done_cyc = cyc;
            end else if (op_valid) begin
                if (!have) begin
                    have = 1;
                    cur  = {op_code, op_dst};
                    dly  = $urandom_range(0, maxdly);
                    if (exp_q.size() == 0) check_val("extra_cmd", ncmd, exp_len);
                    else                   check_val("cmd", cur, exp_q.pop_front());
                    if (abort_at == ncmd) begin
                        #2 rst = 1'b1;
                        #1;
                        check_val("rst_valid", op_valid, 0);
                        check_val("rst_code", op_code, 0);
                        check_val("rst_dst", op_dst, 0);
                        check_val("rst_busy", busy, 0);
                        check_val("rst_cnt", op_cnt, 0);
                        @(negedge clk);
                        rst = 1'b0;
                        exp_q.delete();
                        return;
                    end
                end else begin
                    check_val("cmd_stable", {op_code, op_dst}, cur);
                end
                if (dly == 0) begin
                    op_done = 1'b1;
                    case (cur[2:1])
                        CLR:  r[cur[0]] = 0;
                        LOAD: r[cur[0]] = 1;
                        DBL:  r[cur[0]] = 2 * r[cur[0]];
                        default: r[cur[0]] = r[0] + r[1];
                    endcase
                    have = 0;
                    ncmd++;
                end else begin
                    dly--;
                end
            end else if (have) begin
                check_val("valid_held", op_valid, 1);
            end
            if (poke && cyc == 3 && !fin) begin
                start = 1'b1;
                k_in  = BW_K'($urandom);
            end
        end

        check_val("done_seen", fin, 1);
        if (fin) begin
            last_cnt = op_cnt;
            check_val("result_inf", result_inf, (kv == '0));
            check_val("op_cnt", op_cnt, exp_len);
            check_val("busy_in_done", busy, 0);
            check_val("cmds_left", exp_q.size(), 0);
            if (exp_len > 0) check_val("r0_equals_k", r[0], kv);
            if (maxdly == 0 || exp_len == 0) check_val("done_cycle", done_cyc, exp_len);
            @(negedge clk);
            check_val("done_one_cycle", done, 0);
            check_val("inf_held", result_inf, (kv == '0));
            check_val("cnt_held", op_cnt, exp_len);
        end
    endtask

    // ---- main sequence --------------------------------------------------------
    initial begin
        rst = 1'b1; start = 1'b0; op_done = 1'b0; k_in = '0; sel = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check_val("reset_busy", busy, 0);
            check_val("reset_valid", op_valid, 0);
            check_val("reset_done", done, 0);
            check_val("reset_inf", result_inf, 0);
            check_val("reset_cnt", op_cnt, 0);
        end
        @(negedge clk);
        rst = 1'b0;

        run_job(8'hB5, 1'b0, 0, 1'b0, -1);
        check_val("b5_dadd_count", last_cnt, 13);
        run_job(8'hB5, 1'b1, 0, 1'b0, -1);
        check_val("b5_ladder_count", last_cnt, 18);
        run_job(8'h00, 1'b0, 4, 1'b0, -1);
        run_job(8'h00, 1'b1, 3, 1'b0, -1);
        run_job(8'h01, 1'b0, 0, 1'b0, -1);
        check_val("k1_count", last_cnt, 2);
        run_job(8'h80, 1'b0, 2, 1'b0, -1);
        run_job(8'hFF, 1'b0, 20, 1'b1, -1);
        run_job(8'hFF, 1'b1, 20, 1'b1, -1);

        // Spurious op_done while idle must not move anything.
        sel = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            op_done = 1'b1;
        end
        @(negedge clk);
        op_done = 1'b0;
        check_val("idle_done_cnt", op_cnt, last_cnt);
        check_val("idle_done_valid", op_valid, 0);
        check_val("idle_done_busy", busy, 0);

        // Reset hit while the first BIT_B of a ladder job is outstanding.
        run_job(8'hB5, 1'b1, 4, 1'b0, 3);
        run_job(8'h03, 1'b1, 2, 1'b0, -1);
        check_val("after_reset_count", last_cnt, 18);

        for (int j = 0; j < 24; j++) begin
            logic [BW_K-1:0] kr;
            kr = BW_K'($urandom);
            if ($urandom_range(0, 7) == 0) kr = BW_K'($urandom_range(0, 3));
            run_job(kr, 1'($urandom_range(0, 1)), $urandom_range(0, 20),
                    1'($urandom_range(0, 1)), -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
